// File: rtl/xres_deglitch.sv
// External reset deglitcher: per-channel sync, filter FSM, release stretch.
// Optional sticky event flags when XRES_DEGLITCH_STICKY_EN is defined.
module xres_deglitch #(
    parameter int NCH            = 2,
    parameter int FILT_CYCLES    = 16,
    parameter int STRETCH_CYCLES = 64,
    parameter int SYNC_STAGES    = 2
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    input  logic [NCH-1:0] xres_n_i,
    input  logic [NCH-1:0] chan_en_i,
    input  logic [NCH-1:0] bypass_i,
    output logic [NCH-1:0] rst_n_o,
    output logic           rst_any_n_o,
    output logic [NCH-1:0] event_o
`ifdef XRES_DEGLITCH_STICKY_EN
    ,
    output logic [NCH-1:0] evt_sticky_o,
    input  logic [NCH-1:0] evt_clr_i
`endif
);

    localparam int MAXC = (FILT_CYCLES > STRETCH_CYCLES) ? FILT_CYCLES : STRETCH_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        IDLE,
        ASSERT_PEND,
        ACTIVE,
        RELEASE_PEND,
        STRETCH
    } state_e;

    localparam state_e REL_DONE = (STRETCH_CYCLES == 0) ? IDLE : STRETCH;

    logic [NCH-1:0] sync_q [SYNC_STAGES];
    logic [NCH-1:0] sync;

    state_e         state_q [NCH];
    state_e         state_d [NCH];
    logic [CW-1:0]  cnt_q   [NCH];
    logic [CW-1:0]  cnt_d   [NCH];
    logic [NCH-1:0] rst_n_q, rst_n_d;
    logic [NCH-1:0] evt_q, evt_d;
    logic           rst_any_q, rst_any_d;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= xres_n_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            evt_d[k]   = 1'b0;
            rst_n_d[k] = 1'b1;
            if (!chan_en_i[k]) begin
                state_d[k] = IDLE;
                cnt_d[k]   = '0;
            end else if (bypass_i[k]) begin
                // Park the FSM on the matching level so leaving bypass is clean.
                state_d[k] = sync[k] ? IDLE : ACTIVE;
                cnt_d[k]   = '0;
            end else begin
                unique case (state_q[k])
                    IDLE: begin
                        if (!sync[k]) begin
                            if (FILT_CYCLES == 1) begin
                                state_d[k] = ACTIVE;
                                cnt_d[k]   = '0;
                                evt_d[k]   = 1'b1;
                            end else begin
                                state_d[k] = ASSERT_PEND;
                                cnt_d[k]   = CW'(1);
                            end
                        end
                    end
                    ASSERT_PEND: begin
                        if (sync[k]) begin
                            state_d[k] = IDLE;
                            cnt_d[k]   = '0;
                        end else if (int'(cnt_q[k]) + 1 >= FILT_CYCLES) begin
                            state_d[k] = ACTIVE;
                            cnt_d[k]   = '0;
                            evt_d[k]   = 1'b1;
                        end else begin
                            cnt_d[k] = cnt_q[k] + CW'(1);
                        end
                    end
                    ACTIVE: begin
                        if (sync[k]) begin
                            if (FILT_CYCLES == 1) begin
                                state_d[k] = REL_DONE;
                                cnt_d[k]   = '0;
                            end else begin
                                state_d[k] = RELEASE_PEND;
                                cnt_d[k]   = CW'(1);
                            end
                        end
                    end
                    RELEASE_PEND: begin
                        if (!sync[k]) begin
                            state_d[k] = ACTIVE;
                            cnt_d[k]   = '0;
                        end else if (int'(cnt_q[k]) + 1 >= FILT_CYCLES) begin
                            state_d[k] = REL_DONE;
                            cnt_d[k]   = '0;
                        end else begin
                            cnt_d[k] = cnt_q[k] + CW'(1);
                        end
                    end
                    STRETCH: begin
                        if (!sync[k]) begin
                            state_d[k] = ACTIVE;
                            cnt_d[k]   = '0;
                        end else if (int'(cnt_q[k]) + 1 >= STRETCH_CYCLES) begin
                            state_d[k] = IDLE;
                            cnt_d[k]   = '0;
                        end else begin
                            cnt_d[k] = cnt_q[k] + CW'(1);
                        end
                    end
                    default: begin
                        state_d[k] = ACTIVE;
                        cnt_d[k]   = '0;
                    end
                endcase
            end
            if (!chan_en_i[k]) begin
                rst_n_d[k] = 1'b1;
            end else if (bypass_i[k]) begin
                rst_n_d[k] = sync[k];
            end else begin
                rst_n_d[k] = (state_d[k] == IDLE) || (state_d[k] == ASSERT_PEND);
            end
        end
        rst_any_d = &rst_n_d;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= ACTIVE;
                cnt_q[k]   <= '0;
            end
            rst_n_q   <= '0;
            evt_q     <= '0;
            rst_any_q <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            rst_n_q   <= rst_n_d;
            evt_q     <= evt_d;
            rst_any_q <= rst_any_d;
        end
    end

    assign rst_n_o     = rst_n_q;
    assign rst_any_n_o = rst_any_q;
    assign event_o     = evt_q;

`ifdef XRES_DEGLITCH_STICKY_EN
    logic [NCH-1:0] sticky_q, sticky_d;

    // A new event beats a coincident clear.
    assign sticky_d = evt_q | (sticky_q & ~evt_clr_i);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign evt_sticky_o = sticky_q;
`endif

endmodule

// File: tb/tb_xres_deglitch.sv
// Bench for xres_deglitch: directed scenarios plus random pads
// checked against a run-length reference model.
module tb_xres_deglitch;

    localparam int NCH  = 2;
    localparam int FILT = 16;
    localparam int STR  = 64;
    localparam int SS   = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] xres = '1;
    logic [NCH-1:0] en = '1;
    logic [NCH-1:0] byp = '0;
    logic [NCH-1:0] clr = '0;
    logic [NCH-1:0] rst_n;
    logic           rst_any;
    logic [NCH-1:0] evt;
`ifdef XRES_DEGLITCH_STICKY_EN
    logic [NCH-1:0] sticky;
`endif

    xres_deglitch #(
        .NCH(NCH), .FILT_CYCLES(FILT), .STRETCH_CYCLES(STR), .SYNC_STAGES(SS)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .xres_n_i   (xres),
        .chan_en_i  (en),
        .bypass_i   (byp),
        .rst_n_o    (rst_n),
        .rst_any_n_o(rst_any),
        .event_o    (evt)
`ifdef XRES_DEGLITCH_STICKY_EN
        ,
        .evt_sticky_o(sticky),
        .evt_clr_i   (clr)
`endif
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Reference model: a channel is "asserted" after FILT consecutive low
    // samples and released after FILT+STR consecutive high samples.
    bit             pipe     [NCH][SS];
    bit             asserted [NCH];
    int             lo_run   [NCH];
    int             hi_run   [NCH];
    logic [NCH-1:0] exp_rst_n;
    logic [NCH-1:0] exp_evt;
    logic           exp_any;
    logic [NCH-1:0] evt_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            for (int i = 0; i < SS; i++) pipe[k][i] = 1'b0;
            asserted[k] = 1'b1;
            lo_run[k]   = 0;
            hi_run[k]   = 0;
        end
        exp_rst_n = '0;
        exp_evt   = '0;
        exp_any   = 1'b0;
    endtask

    task automatic model_edge();
        bit s;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NCH; k++) begin
            s = pipe[k][SS-1];
            for (int i = SS - 1; i > 0; i--) pipe[k][i] = pipe[k][i-1];
            pipe[k][0] = xres[k];
            exp_evt[k] = 1'b0;
            if (!en[k]) begin
                asserted[k] = 1'b0;
                lo_run[k] = 0;
                hi_run[k] = 0;
                exp_rst_n[k] = 1'b1;
            end else if (byp[k]) begin
                asserted[k] = !s;
                lo_run[k] = 0;
                hi_run[k] = 0;
                exp_rst_n[k] = s;
            end else begin
                if (s) begin
                    hi_run[k]++;
                    lo_run[k] = 0;
                end else begin
                    lo_run[k]++;
                    hi_run[k] = 0;
                end
                if (!asserted[k] && lo_run[k] >= FILT) begin
                    asserted[k] = 1'b1;
                    exp_evt[k] = 1'b1;
                end else if (asserted[k] && hi_run[k] >= FILT + STR) begin
                    asserted[k] = 1'b0;
                end
                exp_rst_n[k] = !asserted[k];
            end
        end
        exp_any = &exp_rst_n;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        evt_acc |= evt;
        chk("model_rst_n", rst_n, exp_rst_n);
        chk("model_any", rst_any, exp_any);
        chk("model_evt", evt, exp_evt);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rst_n", rst_n, 0);
        chk("reset_any", rst_any, 0);
        chk("reset_evt", evt, 0);
        @(negedge clk);
        rst = 1'b0;

        // Release from reset with pads high
        repeat (81) step();
        chk("rel_edge81", rst_n, 0);
        chk("rel_any81", rst_any, 0);
        step();
        chk("rel_edge82", rst_n, 3);
        chk("rel_any82", rst_any, 1);

        // Short glitch is filtered
        evt_acc = '0;
        xres[0] = 1'b0;
        repeat (10) step();
        xres[0] = 1'b1;
        repeat (20) step();
        chk("glitch_evt", evt_acc, 0);
        chk("glitch_rst_n", rst_n, 3);

        // Long assertion then release
        xres[0] = 1'b0;
        repeat (17) step();
        chk("assert_e17", rst_n[0], 1);
        step();
        chk("assert_e18", rst_n[0], 0);
        chk("assert_evt", evt, 1);
        clr = 2'b01;
        step();
        chk("assert_evt_one", evt, 0);
`ifdef XRES_DEGLITCH_STICKY_EN
        chk("sticky_set_wins", sticky[0], 1);
`endif
        step();
`ifdef XRES_DEGLITCH_STICKY_EN
        chk("sticky_cleared", sticky[0], 0);
`endif
        clr = '0;
        repeat (20) step();
        xres[0] = 1'b1;
        repeat (81) step();
        chk("release_e81", rst_n[0], 0);
        step();
        chk("release_e82", rst_n[0], 1);

        // Pad dip during stretch
        xres[0] = 1'b0;
        repeat (40) step();
        xres[0] = 1'b1;
        repeat (28) step();
        chk("stretch_held", rst_n[0], 0);
        evt_acc = '0;
        xres[0] = 1'b0;
        repeat (5) step();
        xres[0] = 1'b1;
        repeat (81) step();
        chk("restretch_e81", rst_n[0], 0);
        chk("restretch_noevt", evt_acc, 0);
        step();
        chk("restretch_e82", rst_n[0], 1);

        // Bypass passes a short pulse
        evt_acc = '0;
        byp[1] = 1'b1;
        xres[1] = 1'b0;
        step();
        step();
        chk("byp_e2", rst_n[1], 1);
        step();
        chk("byp_e3", rst_n[1], 0);
        xres[1] = 1'b1;
        step();
        chk("byp_e4", rst_n[1], 0);
        step();
        chk("byp_e5", rst_n[1], 0);
        step();
        chk("byp_e6", rst_n[1], 1);
        chk("byp_noevt", evt_acc, 0);
        byp[1] = 1'b0;

        // Disabled channel ignores pad; re-enable evaluates from idle
        en[1] = 1'b0;
        xres[1] = 1'b0;
        repeat (20) step();
        chk("dis_rst_n", rst_n[1], 1);
        en[1] = 1'b1;
        repeat (15) step();
        chk("reen_e15", rst_n[1], 1);
        step();
        chk("reen_e16", rst_n[1], 0);
        xres[1] = 1'b1;
        repeat (82) step();

        // Random pads, enables and bypasses, with one mid-run reset
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(29, 0) == 0) xres[k] = ~xres[k];
                if ($urandom_range(299, 0) == 0) byp[k] = ~byp[k];
                if ($urandom_range(399, 0) == 0) en[k] = ~en[k];
            end
            if (i == 2000) begin
                rst = 1'b1;
                #1;
                chk("async_rst_n", rst_n, 0);
                chk("async_evt", evt, 0);
                chk("async_any", rst_any, 0);
                model_reset();
                repeat (3) step();
                rst = 1'b0;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
